// File: rtl/tx_interrupt_ctrl_pkg.sv
// rtl/tx_interrupt_ctrl_pkg.sv - shared mode, FSM and source-index definitions for tx_intf
package tx_intf_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_LATCH  = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FIRE = 1'b1
  } irq_state_e;

  localparam int SRC_TLAST        = 0;
  localparam int SRC_PHY_TX_START = 1;
  localparam int SRC_START_ACC    = 2;
  localparam int SRC_END_ACC      = 3;
  localparam int SRC_TRY_COMPLETE = 4;

endpackage

// File: rtl/tx_interrupt_ctrl_if.sv
// rtl/tx_interrupt_ctrl_if.sv - control/status bundle between register bank and tx_interrupt_ctrl
interface tx_interrupt_ctrl_if #(
  parameter int NUM_SRC   = 8,
  parameter int SEL_WIDTH = 3,
  parameter int CNT_WIDTH = 8
);
  logic [NUM_SRC-1:0]   src_in;
  logic                 mode;
  logic [SEL_WIDTH-1:0] src_sel;
  logic [NUM_SRC-1:0]   irq_mask;
  logic [CNT_WIDTH-1:0] coalesce_thresh;
  logic                 clr_valid;
  logic [NUM_SRC-1:0]   clr_bits;
  logic [NUM_SRC-1:0]   pending;
  logic [CNT_WIDTH-1:0] event_cnt;
  logic                 tx_itrpt;

  modport master (
    output src_in, mode, src_sel, irq_mask, coalesce_thresh, clr_valid, clr_bits,
    input  pending, event_cnt, tx_itrpt
  );

  modport slave (
    input  src_in, mode, src_sel, irq_mask, coalesce_thresh, clr_valid, clr_bits,
    output pending, event_cnt, tx_itrpt
  );
endinterface

// File: rtl/tx_interrupt_ctrl_pulse_stretch.sv
// rtl/tx_interrupt_ctrl_pulse_stretch.sv - IDLE/FIRE FSM stretching an IRQ request to PULSE_LEN cycles
module tx_irq_pulse_stretch
  import tx_intf_pkg::*;
#(
  parameter int PULSE_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic fire_i,
  output logic idle_o,
  output logic irq_o
);

  localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

  irq_state_e    state_q;
  logic [PW-1:0] pcnt_q;
  logic          irq_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pcnt_q  <= '0;
      irq_q   <= 1'b0;
    end else if (!en_i) begin
      state_q <= ST_IDLE;
      pcnt_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fire_i) begin
            state_q <= ST_FIRE;
            irq_q   <= 1'b1;
            pcnt_q  <= PW'(PULSE_LEN - 1);
          end
        end
        ST_FIRE: begin
          // Dropping to IDLE forces at least one low cycle before the next pulse.
          if (pcnt_q == '0) begin
            state_q <= ST_IDLE;
            irq_q   <= 1'b0;
          end else begin
            pcnt_q <= pcnt_q - 1'b1;
          end
        end
      endcase
    end
  end

  assign idle_o = (state_q == ST_IDLE);
  assign irq_o  = irq_q;

endmodule

// File: rtl/tx_interrupt_ctrl.sv
// rtl/tx_interrupt_ctrl.sv - TX interrupt generator: direct select or masked/latched/coalesced IRQ
module tx_interrupt_ctrl
  import tx_intf_pkg::*;
#(
  parameter int NUM_SRC   = 8,
  parameter int SEL_WIDTH = 3,
  parameter int CNT_WIDTH = 8,
  parameter int PULSE_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  tx_interrupt_ctrl_if.slave bus
);

  logic [NUM_SRC-1:0]      src_d_q;
  logic [NUM_SRC-1:0]      pending_q, pending_d;
  logic [NUM_SRC-1:0]      rise, mrise;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d, cnt_sat, eff_thr;
  logic [2**SEL_WIDTH-1:0] src_pad;
  logic                    mode_q, mode_chg, latch_en;
  logic                    direct_q, direct_d;
  logic                    inc, fire, idle, irq;

  always_comb begin
    rise     = bus.src_in & ~src_d_q;
    mrise    = rise & bus.irq_mask;
    inc      = |mrise;
    mode_chg = (bus.mode != mode_q);
    latch_en = (bus.mode == MODE_LATCH) && !mode_chg;
    cnt_sat  = (inc && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
    eff_thr  = (bus.coalesce_thresh == '0) ? CNT_WIDTH'(1) : bus.coalesce_thresh;
    fire     = latch_en && idle && (cnt_sat >= eff_thr);

    // Out-of-range selects land on the zero padding.
    src_pad              = '0;
    src_pad[NUM_SRC-1:0] = bus.src_in;
    direct_d = ((bus.mode == MODE_DIRECT) && !mode_chg) ? src_pad[bus.src_sel] : 1'b0;

    pending_d = pending_q;
    if (latch_en)
      pending_d = (pending_q & ~(bus.clr_valid ? bus.clr_bits : '0)) | mrise;

    // On fire the counted events are consumed; this cycle's event survives only
    // when the threshold was already met without it.
    cnt_d = cnt_q;
    if (mode_chg)
      cnt_d = '0;
    else if (latch_en) begin
      if (fire)
        cnt_d = (cnt_q >= eff_thr) ? CNT_WIDTH'(inc) : '0;
      else
        cnt_d = cnt_sat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_d_q   <= '0;
      mode_q    <= MODE_DIRECT;
      pending_q <= '0;
      cnt_q     <= '0;
      direct_q  <= 1'b0;
    end else begin
      src_d_q   <= bus.src_in;
      mode_q    <= bus.mode;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      direct_q  <= direct_d;
    end
  end

  tx_irq_pulse_stretch #(
    .PULSE_LEN(PULSE_LEN)
  ) u_stretch (
    .clk   (clk),
    .rst   (rst),
    .en_i  (latch_en),
    .fire_i(fire),
    .idle_o(idle),
    .irq_o (irq)
  );

  assign bus.pending   = pending_q;
  assign bus.event_cnt = cnt_q;
  assign bus.tx_itrpt  = direct_q | irq;

endmodule

// File: tb/tb_tx_interrupt_ctrl.sv
// tb/tb_tx_interrupt_ctrl.sv - randomized and directed checks of tx_interrupt_ctrl against a reference model
module tb_tx_interrupt_ctrl;

  localparam int PL = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tx_interrupt_ctrl_if #(.NUM_SRC(8), .SEL_WIDTH(3), .CNT_WIDTH(8)) bus ();
  tx_interrupt_ctrl_if #(.NUM_SRC(5), .SEL_WIDTH(3), .CNT_WIDTH(8)) bus5 ();

  tx_interrupt_ctrl #(.NUM_SRC(8), .SEL_WIDTH(3), .CNT_WIDTH(8), .PULSE_LEN(PL)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  tx_interrupt_ctrl #(.NUM_SRC(5), .SEL_WIDTH(3), .CNT_WIDTH(8), .PULSE_LEN(PL)) dut5 (
    .clk(clk), .rst(rst), .bus(bus5)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [7:0] m_prev, m_pend;
  logic       m_mode, m_tx;
  int         m_cnt, m_high;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int sat8(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic model_reset();
    m_prev = '0; m_pend = '0; m_mode = 1'b0; m_tx = 1'b0; m_cnt = 0; m_high = 0;
  endtask

  // m_high: remaining high cycles of the current pulse, counting the present one.
  task automatic model_step();
    logic [7:0] r;
    int inc, thr, nxt;
    thr = (bus.coalesce_thresh == 0) ? 1 : int'(bus.coalesce_thresh);
    r   = bus.src_in & ~m_prev & bus.irq_mask;
    inc = (r != 0) ? 1 : 0;
    nxt = sat8(m_cnt + inc);
    if (bus.mode != m_mode) begin
      m_cnt = 0; m_tx = 1'b0; m_high = 0;
    end else if (bus.mode == 1'b0) begin
      m_tx = bus.src_in[bus.src_sel];
    end else begin
      m_pend = (m_pend & ~(bus.clr_valid ? bus.clr_bits : 8'h00)) | r;
      if (m_high > 0) begin
        m_high--;
        m_tx  = (m_high > 0);
        m_cnt = nxt;
      end else if (nxt >= thr) begin
        m_tx   = 1'b1;
        m_high = PL;
        m_cnt  = (m_cnt >= thr) ? inc : 0;
      end else begin
        m_cnt = nxt;
      end
    end
    m_prev = bus.src_in;
    m_mode = bus.mode;
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_step();
      cyc++;
      #1;
      chk("pending",   32'(bus.pending),   32'(m_pend));
      chk("event_cnt", 32'(bus.event_cnt), 32'(m_cnt));
      chk("tx_itrpt",  32'(bus.tx_itrpt),  32'(m_tx));
    end
  endtask

  task automatic pulse_src(input logic [7:0] v);
    bus.src_in = v; tick();
    bus.src_in = 8'h00; tick();
  endtask

  initial begin
    rst = 1'b1;
    bus.src_in = '0; bus.mode = 1'b0; bus.src_sel = '0; bus.irq_mask = '0;
    bus.coalesce_thresh = '0; bus.clr_valid = 1'b0; bus.clr_bits = '0;
    bus5.src_in = 5'h1f; bus5.mode = 1'b0; bus5.src_sel = 3'd6; bus5.irq_mask = '0;
    bus5.coalesce_thresh = '0; bus5.clr_valid = 1'b0; bus5.clr_bits = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pending", 32'(bus.pending), 0);
    chk("rst_event_cnt", 32'(bus.event_cnt), 0);
    chk("rst_tx_itrpt", 32'(bus.tx_itrpt), 0);
    rst = 1'b0;

    // Direct select
    bus.src_sel = 3'd3;
    tick(2);
    pulse_src(8'h08);
    tick(2);
    pulse_src(8'hf7);
    chk("dut5_sel6_tx", 32'(bus5.tx_itrpt), 0);
    bus5.src_sel = 3'd7; tick(2);
    chk("dut5_sel7_tx", 32'(bus5.tx_itrpt), 0);
    bus5.src_sel = 3'd4; tick(1);
    chk("dut5_sel4_tx", 32'(bus5.tx_itrpt), 1);

    // Latched, single event and masked event
    bus.mode = 1'b1; bus.irq_mask = 8'h01; bus.coalesce_thresh = 8'd1;
    tick(2);
    pulse_src(8'h01);
    tick(6);
    chk("single_pending", 32'(bus.pending), 32'h01);
    pulse_src(8'h04);
    tick(6);

    // Coalescing with threshold 3
    bus.clr_valid = 1'b1; bus.clr_bits = 8'hff; tick(); bus.clr_valid = 1'b0;
    bus.irq_mask = 8'hff; bus.coalesce_thresh = 8'd3;
    for (int i = 0; i < 20; i++) begin
      bus.src_in = (i == 0 || i == 5 || i == 9) ? 8'h01 : 8'h00;
      tick();
    end
    bus.coalesce_thresh = 8'd2;
    pulse_src(8'h07);
    tick(2);
    chk("same_cycle_cnt", 32'(bus.event_cnt), 1);
    pulse_src(8'h10);
    tick(8);

    // Back-to-back pulses
    bus.coalesce_thresh = 8'd1;
    pulse_src(8'h01);
    tick(1);
    pulse_src(8'h02);
    tick(12);

    // Write-1-to-clear, set wins
    bus.clr_valid = 1'b1; bus.clr_bits = 8'hff; tick(); bus.clr_valid = 1'b0;
    pulse_src(8'h05);
    tick(6);
    bus.clr_valid = 1'b1; bus.clr_bits = 8'h04; tick(); bus.clr_valid = 1'b0;
    chk("w1c_pending", 32'(bus.pending), 32'h01);
    bus.src_in = 8'h01; bus.clr_valid = 1'b1; bus.clr_bits = 8'h01; tick();
    bus.clr_valid = 1'b0; bus.src_in = 8'h00;
    chk("set_wins", 32'(bus.pending[0]), 1);
    tick(8);

    // Lowered threshold fires immediately
    bus.coalesce_thresh = 8'd8;
    for (int i = 0; i < 3; i++) pulse_src(8'h20);
    bus.coalesce_thresh = 8'd2;
    tick(8);

    // Reset mid-pulse, source held high across it
    bus.coalesce_thresh = 8'd1;
    bus.src_in = 8'h01; tick(2);
    #3 rst = 1'b1;
    #1;
    chk("amid_rst_tx", 32'(bus.tx_itrpt), 0);
    chk("amid_rst_pending", 32'(bus.pending), 0);
    chk("amid_rst_cnt", 32'(bus.event_cnt), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    tick(6);
    chk("held_no_edge", 32'(bus.pending), 0);
    bus.src_in = 8'h00; tick();
    bus.src_in = 8'h01; tick(6);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 8; b++)
        if ($urandom_range(5) == 0) bus.src_in[b] = ~bus.src_in[b];
      if ($urandom_range(49) == 0) bus.irq_mask = 8'($urandom);
      if ($urandom_range(39) == 0) bus.coalesce_thresh = 8'($urandom_range(4));
      if ($urandom_range(19) == 0) bus.src_sel = 3'($urandom);
      if ($urandom_range(299) == 0) bus.mode = ~bus.mode;
      bus.clr_valid = ($urandom_range(7) == 0);
      bus.clr_bits  = 8'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
